switch_debounce_sync: RTL

//  Front-end conditioner for the board slide switches feeding the A/B/C logic inputs.
//  - Synchronises each raw switch line into clk.
//  - Filters out contact bounce and presents clean, stable levels.
//  - sw_out[0]=A, sw_out[1]=B, sw_out[2]=C go straight into the combinational gate stage.
//  - Pulses `changed` whenever any committed level moves.

---
 rtl/switch_debounce_sync.sv | 70 +++++++
 1 files changed

// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: two-flop synchroniser plus per-channel debounce FSM for raw switch levels
// Ports: clk; rst (sync, active-high); sw_in raw async levels; sw_out committed debounced levels;
//   changed 1-cycle pulse when any sw_out bit commits; rise/fall per-bit 0->1 / 1->0 commit pulses.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN (adds rise/fall ports and logic).
module switch_debounce_sync #(
  parameter int WIDTH = 3,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`endif
  output logic             changed
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {STABLE, CHANGING} state_t;
  logic [WIDTH-1:0] s1_q, s2_q, commit;
  logic changed_q;
  always_ff @(posedge clk) begin
    s1_q <= rst ? '0 : sw_in;
    s2_q <= rst ? '0 : s1_q;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic out_q;
    // commit fires on the edge the terminal count sees the new level still held
    assign commit[i] = state_q == CHANGING && s2_q[i] != out_q && cnt_q == CNT_MAX;
    assign sw_out[i] = out_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= STABLE;
        cnt_q <= '0;
        out_q <= 1'b0;
      end else if (state_q == STABLE) begin
        if (s2_q[i] != out_q) begin
          state_q <= CHANGING;
          cnt_q <= '0;
        end
      end else if (s2_q[i] == out_q) begin
        state_q <= STABLE;
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        out_q <= s2_q[i];
        state_q <= STABLE;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk)
    changed_q <= rst ? 1'b0 : |commit;
  assign changed = changed_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [WIDTH-1:0] rise_q, fall_q;
  // on a commit the new level equals s2, so s2 gives the edge direction
  always_ff @(posedge clk) begin
    rise_q <= rst ? '0 : commit & s2_q;
    fall_q <= rst ? '0 : commit & ~s2_q;
  end
  assign rise = rise_q;
  assign fall = fall_q;
`endif
endmodule
